// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO plus request sequencer feeding an 8N1 UART
// transmitter. A producer pushes bytes through wr_valid/wr_ready. The block
// presents one byte at a time to the transmitter using its level handshake.
// tx_send rises while the transmitter is idle. The byte is popped once
// tx_ready falls, which means the transmitter has captured it.
//
// Ports:
//   clk       system clock
//   reset_n   asynchronous active-low reset
//   wr_data   byte to enqueue
//   wr_valid  producer offers wr_data this cycle
//   wr_ready  FIFO can accept (!full && !flush), combinational
//   flush     synchronous clear of contents and overflow flag
//   tx_ready  transmitter idle
//   tx_send   registered request to the transmitter
//   tx_data   head byte, meaningful while tx_send=1
//   level     number of stored bytes, 0..2**DEPTH_LOG2
//   empty     level == 0
//   full      level == 2**DEPTH_LOG2
//   overflow  sticky: a write was offered while full
module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_W     = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic                  flush,
    input  logic                  tx_ready,
    output logic                  tx_send,
    output logic [DATA_W-1:0]     tx_data,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   LEVEL_FULL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   LEVEL_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic                    tx_send_q, tx_send_d;
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]     level_q, level_d;
    logic                    overflow_q, overflow_d;
    logic [DATA_W-1:0]       mem_q [DEPTH];

    logic                    wr_en;
    logic                    pop;

    assign empty    = (level_q == '0);
    assign full     = (level_q == LEVEL_FULL);
    assign wr_ready = !full && !flush;
    assign wr_en    = wr_valid && wr_ready;
    assign tx_send  = tx_send_q;
    assign tx_data  = mem_q[rd_ptr_q];
    assign level    = level_q;
    assign overflow = overflow_q;

    // Request sequencer. A pop happens only when the transmitter drops
    // tx_ready while our request is up, so each byte goes out exactly once.
    always_comb begin
        state_d   = state_q;
        tx_send_d = tx_send_q;
        pop       = 1'b0;
        case (state_q)
            S_IDLE: begin
                tx_send_d = 1'b0;
                if (!empty && tx_ready && !flush) begin
                    tx_send_d = 1'b1;
                    state_d   = S_REQ;
                end
            end
            S_REQ: begin
                if (flush) begin
                    // Flushed before capture: drop the request without popping.
                    tx_send_d = 1'b0;
                    state_d   = S_IDLE;
                end else if (!tx_ready) begin
                    pop       = 1'b1;
                    tx_send_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                tx_send_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    // Pointer, level and overflow bookkeeping; flush overrides everything.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({wr_en, pop})
                2'b10:   level_d = level_q + LEVEL_ONE;
                2'b01:   level_d = level_q - LEVEL_ONE;
                default: level_d = level_q;
            endcase
            // Judged on the pre-edge fill, so a same-edge pop does not rescue it.
            if (wr_valid && full) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            tx_send_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_send_q  <= tx_send_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is not reset. While a request is up the FIFO is non-empty and
    // full writes are refused, so the head slot is never overwritten.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo. It contains a behavioural 8N1 transmitter with
// the level handshake, a serial receiver that decodes the line, and a
// queue-based reference of the bytes that should appear on the line.
module tb_uart_tx_fifo;
    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;
    logic       flush;
    logic       tx_ready;
    logic       tx_send;
    logic [7:0] tx_data;
    logic [4:0] level;
    logic       empty;
    logic       full;
    logic       overflow;

    uart_tx_fifo #(.DEPTH_LOG2(4), .DATA_W(8)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .flush    (flush),
        .tx_ready (tx_ready),
        .tx_send  (tx_send),
        .tx_data  (tx_data),
        .level    (level),
        .empty    (empty),
        .full     (full),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int bit_cyc = 8;
    logic gate = 1'b0;   // forces tx_ready low and blocks capture
    logic hold = 1'b0;   // transmitter stays idle (ready=1) but refuses capture

    logic [7:0] exp_q[$];
    logic [8:0] rx_q[$];
    int         pulse_q[$];
    int         acc_cnt = 0;
    int         cap_cnt = 0;
    logic       exp_ovf = 1'b0;

    // Behavioural transmitter: capture while idle, shift 10 bits, then
    // wait for tx_send to drop before becoming idle again.
    int         t_st;
    int         t_cnt;
    int         t_bit;
    logic [9:0] t_sh;
    logic       txd;

    assign tx_ready = (t_st == 0) && !gate;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            t_st <= 0;
            txd  <= 1'b1;
        end else begin
            case (t_st)
                0: if (tx_send && !gate && !hold) begin
                    t_sh    <= {1'b1, tx_data, 1'b0};
                    txd     <= 1'b0;
                    t_cnt   <= 1;
                    t_bit   <= 0;
                    t_st    <= 1;
                    cap_cnt <= cap_cnt + 1;
                end
                1: if (t_cnt == bit_cyc) begin
                    t_cnt <= 1;
                    if (t_bit == 9) begin
                        t_st <= 2;
                        txd  <= 1'b1;
                    end else begin
                        t_bit <= t_bit + 1;
                        txd   <= t_sh[t_bit+1];
                    end
                end else begin
                    t_cnt <= t_cnt + 1;
                end
                default: if (!tx_send) t_st <= 0;
            endcase
        end
    end

    // Serial receiver: mid-bit sampling; pushes {stop, data}.
    int         r_st;
    int         r_cnt;
    int         r_bit;
    logic [7:0] r_sh;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_st <= 0;
        end else begin
            case (r_st)
                0: if (txd == 1'b0) begin
                    r_st  <= 1;
                    r_cnt <= 1;
                end
                1: if (r_cnt == bit_cyc/2) begin
                    r_cnt <= 1;
                    r_bit <= 0;
                    r_st  <= (txd == 1'b0) ? 2 : 0;
                end else begin
                    r_cnt <= r_cnt + 1;
                end
                2: if (r_cnt == bit_cyc) begin
                    r_cnt       <= 1;
                    r_sh[r_bit] <= txd;
                    if (r_bit == 7) r_st <= 3;
                    else            r_bit <= r_bit + 1;
                end else begin
                    r_cnt <= r_cnt + 1;
                end
                default: if (r_cnt == bit_cyc) begin
                    rx_q.push_back({txd, r_sh});
                    r_st <= 0;
                end else begin
                    r_cnt <= r_cnt + 1;
                end
            endcase
        end
    end

    // tx_send pulse widths in clocks.
    int p_cnt = 0;
    always @(posedge clk) begin
        if (tx_send) begin
            p_cnt = p_cnt + 1;
        end else if (p_cnt > 0) begin
            pulse_q.push_back(p_cnt);
            p_cnt = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer one byte for one clock; the reference decides acceptance.
    task automatic put(input logic [7:0] b);
        wr_valid = 1'b1;
        wr_data  = b;
        if (!flush && (acc_cnt - cap_cnt) < 16) begin
            exp_q.push_back(b);
            acc_cnt++;
        end else if (!flush) begin
            exp_ovf = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic check_rx(input string tag, input int n);
        logic [8:0] r;
        logic [7:0] e;
        int t;
        for (int i = 0; i < n; i++) begin
            t = 0;
            while (rx_q.size() == 0 && t < 12*bit_cyc + 4000) begin
                @(negedge clk);
                t++;
            end
            if (rx_q.size() == 0) begin
                chk({tag, "_rx_timeout"}, rx_q.size(), 1);
                return;
            end
            r = rx_q.pop_front();
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            chk({tag, "_byte"}, {24'd0, r[7:0]}, {24'd0, e});
            chk({tag, "_stop"}, {31'd0, r[8]}, 1);
        end
    endtask

    task automatic wait_idle(input string tag);
        int t;
        t = 0;
        while (!(t_st == 0 && r_st == 0 && empty && !tx_send) && t < 20*bit_cyc + 4000) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_idle"}, {31'd0, empty && !tx_send && t_st == 0}, 1);
    endtask

    initial begin
        int t;
        reset_n  = 1'b0;
        wr_valid = 1'b1;
        wr_data  = 8'h3C;
        flush    = 1'b0;

        // Reset with a write held: nothing enters until reset_n rises.
        repeat (3) @(negedge clk);
        chk("rst_level",    {27'd0, level}, 0);
        chk("rst_empty",    {31'd0, empty}, 1);
        chk("rst_full",     {31'd0, full}, 0);
        chk("rst_tx_send",  {31'd0, tx_send}, 0);
        chk("rst_overflow", {31'd0, overflow}, 0);
        chk("rst_wr_ready", {31'd0, wr_ready}, 1);
        reset_n = 1'b1;
        put(8'h3C);
        wr_valid = 1'b0;
        chk("rst_first_wr_level", {27'd0, level}, 1);
        check_rx("rst_first", 1);
        wait_idle("rst_first");

        // Single byte 0x55 at the real bit period; cycle-exact latency.
        bit_cyc = 234;
        put(8'h55);
        wr_valid = 1'b0;
        chk("lat_e0_tx_send", {31'd0, tx_send}, 0);
        chk("lat_e0_level",   {27'd0, level}, 1);
        @(negedge clk);
        chk("lat_e1_tx_send", {31'd0, tx_send}, 1);
        @(negedge clk);
        chk("lat_e2_tx_send", {31'd0, tx_send}, 1);
        @(negedge clk);
        chk("lat_e3_tx_send", {31'd0, tx_send}, 0);
        chk("lat_e3_level",   {27'd0, level}, 0);
        check_rx("b55", 1);
        wait_idle("b55");
        bit_cyc = 8;

        // "HELLO" burst queued behind a busy transmitter, then released.
        gate = 1'b1;
        put(8'h48); put(8'h45); put(8'h4C); put(8'h4C); put(8'h4F);
        wr_valid = 1'b0;
        chk("hello_level", {27'd0, level}, acc_cnt - cap_cnt);
        pulse_q.delete();
        gate = 1'b0;
        check_rx("hello", 5);
        wait_idle("hello");
        chk("hello_pulses", pulse_q.size(), 5);
        foreach (pulse_q[i]) chk("hello_pulse_w", pulse_q[i], 2);

        // Fill to full with the transmitter blocked; the 17th byte is dropped.
        gate = 1'b1;
        for (int i = 0; i < 17; i++) begin
            put(8'(i));
            if (i == 15) begin
                chk("full_flag",     {31'd0, full}, 1);
                chk("full_wr_ready", {31'd0, wr_ready}, 0);
            end
        end
        wr_valid = 1'b0;
        chk("full_level",    {27'd0, level}, acc_cnt - cap_cnt);
        chk("full_overflow", {31'd0, overflow}, {31'd0, exp_ovf});
        gate = 1'b0;
        check_rx("full_drain", 16);
        wait_idle("full_drain");
        repeat (50) @(negedge clk);
        chk("full_no_extra", rx_q.size(), 0);
        chk("full_ovf_sticky", {31'd0, overflow}, {31'd0, exp_ovf});

        // Throttled random traffic across pointer wrap.
        for (int i = 0; i < 40; i++) begin
            t = 0;
            while (level >= 15 && t < 4000) begin
                @(negedge clk);
                t++;
            end
            if (level >= 15) chk("wrap_throttle", {27'd0, level}, 14);
            repeat ($urandom_range(0, 30)) @(negedge clk);
            put(8'($urandom));
            wr_valid = 1'b0;
        end
        check_rx("wrap", 40);
        wait_idle("wrap");

        // Flush while a request is pending and not yet captured.
        hold = 1'b1;
        put(8'hA7);
        wr_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("fl_pre_tx_send", {31'd0, tx_send}, 1);
        chk("fl_pre_level",   {27'd0, level}, acc_cnt - cap_cnt);
        chk("fl_pre_ovf",     {31'd0, overflow}, {31'd0, exp_ovf});
        flush = 1'b1;
        #1;
        chk("fl_wr_ready", {31'd0, wr_ready}, 0);
        put(8'hEE);
        wr_valid = 1'b0;
        flush    = 1'b0;
        exp_ovf  = 1'b0;
        exp_q.delete();
        acc_cnt  = cap_cnt;
        chk("fl_tx_send", {31'd0, tx_send}, 0);
        chk("fl_level",   {27'd0, level}, 0);
        chk("fl_empty",   {31'd0, empty}, 1);
        chk("fl_ovf",     {31'd0, overflow}, {31'd0, exp_ovf});
        put(8'h5A);
        wr_valid = 1'b0;
        chk("fl_after_level", {27'd0, level}, acc_cnt - cap_cnt);
        hold = 1'b0;
        check_rx("fl_after", 1);
        wait_idle("fl_after");
        repeat (50) @(negedge clk);
        chk("fl_no_extra", rx_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "global timeout");
    end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte FIFO and request sequencer that feeds the UART transmitter (tx_send/tx_data/tx_ready, 8N1, 27 MHz, 115200 baud).
- Accepts bytes from a producer (CPU/packet logic) via valid/ready and queues them.
- Issues one transmitter request per byte, following the transmitter's level handshake: it latches data while idle with tx_send high, then waits for tx_send low before accepting the next byte.
- Lets producers burst strings without tracking per-byte frame timing.

Parameters:
- DEPTH_LOG2, 4: FIFO depth = 2**DEPTH_LOG2 entries (16).
- DATA_W, 8: byte width. Fixed at 8 to match the transmitter.

Ports:
- clk  in  1  system clock, 27 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- wr_data  in  DATA_W  byte to enqueue.
- wr_valid  in  1  producer offers wr_data this cycle.
- wr_ready  out  1  FIFO can accept; equals !full && !flush (combinational).
- flush  in  1  synchronous clear of FIFO contents and overflow flag.
- tx_ready  in  1  transmitter idle (from transmitter).
- tx_send  out  1  registered request to transmitter.
- tx_data  out  DATA_W  FIFO head byte. Combinational mem[rd_ptr]; valid only while tx_send=1.
- level  out  DEPTH_LOG2+1  number of stored bytes, 0..16.
- empty  out  1  level==0.
- full  out  1  level==2**DEPTH_LOG2.
- overflow  out  1  sticky; set when wr_valid=1 while full; cleared by flush or reset.

Behaviour:
- Reset (async, reset_n=0):
  - rd_ptr=wr_ptr=0, level=0, empty=1, full=0, wr_ready=1, overflow=0.
  - tx_send=0, state=S_IDLE.
  - Memory is not reset.
- Storage: circular buffer with DEPTH_LOG2-bit pointers that wrap modulo depth. level is a separate DEPTH_LOG2+1-bit counter.
- Write: wr_valid && wr_ready at an edge stores wr_data at wr_ptr; wr_ptr+1; level+1.
  - Write while full is dropped, sets overflow, and leaves contents unchanged.
- Pop: only in S_REQ on acceptance (see below); rd_ptr+1; level-1.
  - Same-edge write and pop leaves level unchanged.
  - A write while full is rejected even if a pop occurs on that edge.
- FSM:
  - S_IDLE: tx_send=0. If !empty && tx_ready && !flush, then tx_send<=1 and go to S_REQ.
  - S_REQ: tx_send=1, tx_data held at head.
    - If tx_ready==0 (transmitter captured the byte and left idle), then pop, tx_send<=0, go to S_IDLE.
    - Otherwise stay in S_REQ.
  - After returning to S_IDLE, the block waits for tx_ready to rise again: transmitter frame done, WAIT saw tx_send=0, back in IDLE.
- tx_data stability: during S_REQ the head slot cannot be overwritten. The FIFO is non-empty and writes while full are rejected, so wr_ptr never equals rd_ptr for a write.
- Latency: with the FIFO empty and transmitter idle, a byte written at edge E0 gives:
  - tx_send=1 after E1;
  - transmitter captures at E2;
  - pop and tx_send=0 at E3.
  - One byte is sent per transmitter frame; no byte is repeated or skipped.
- Flush (synchronous, priority over write):
  - Sets pointers and level to 0, clears overflow, sets wr_ready=0 that cycle.
  - If in S_REQ: tx_send<=0, go to S_IDLE, no pop.
  - A byte the transmitter captured on or before the flush edge still completes on the line. It is not recalled.
- Reset mid-frame: FIFO is emptied and tx_send drops immediately (async). The transmitter shares reset_n and aborts as well.

Test Plan:
- Reset with wr_valid=1 held -> level=0, empty=1, tx_send=0, overflow=0; writes start only after reset_n rises.
- Write 8'h55 into empty FIFO, transmitter idle (CYCLE=234) -> tx_send high 1 clock after the write edge.
  - Serial line carries start=0, then 1,0,1,0,1,0,1,0 LSB-first, then stop=1.
  - tx_send low 2 clocks after it rose; level back to 0.
- Burst "HELLO" (48 45 4C 4C 4F) in 5 consecutive cycles -> level peaks at 5.
  - Serial decode yields exactly 48,45,4C,4C,4F in order.
  - Each tx_send pulse is 2 cycles; there are 5 pulses total.
- Write 17 bytes 00..10 with tx_ready forced 0 -> full=1 after 16th; wr_ready=0; 17th dropped; overflow=1.
  - Release tx_ready -> bytes 00..0F are sent and byte 10 is never sent.
- Pointer wrap: 40 bytes at a throttled rate keeping level between 1 and 15 -> all 40 bytes sent in order across pointer wrap.
- Flush in S_REQ before capture (tx_ready held 1 externally gated low) -> tx_send falls next cycle, level=0, overflow cleared.
  - A write in the same cycle is dropped; a write the following cycle is accepted and sent normally.
